fetch_ctrl: RTL and testbench

Control-side partner of the fetch unit. It drives the fetch unit's start/start_addr/branch/target/taken/halt inputs and consumes its PC. It sequences program launch, run and halt, resolves conditional branches against a registered ALU zero flag and a hardware loop counter, and counts executed cycles. It sits between decode/ALU and fetch.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/sat_counter.sv | 29 ++
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch control slice: controller state,
// branch condition encodings and default widths.
package fetch_pkg;

  localparam int PC_W_DEF   = 8;
  localparam int CYC_W_DEF  = 32;
  localparam int LOOP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_LOOP   = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Launch/run/halt sequencer and branch resolver in front of the fetch unit.
// Define BRANCH_STATS_EN to add the br_count/taken_count statistics outputs.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int CYC_W  = CYC_W_DEF,
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [PC_W-1:0]   go_addr,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              br_valid,
  input  logic [1:0]        br_cond,
  input  logic [PC_W-1:0]   br_offset,
  input  logic              alu_zero,
  input  logic              flag_we,
  input  logic              loop_ld,
  input  logic [LOOP_W-1:0] loop_val,
  input  logic              halt_instr,
  output logic              start,
  output logic [PC_W-1:0]   start_addr,
  output logic              branch,
  output logic [PC_W-1:0]   target,
  output logic              taken,
  output logic              halt,
  output logic              running,
  output logic              done,
  output logic [CYC_W-1:0]  cycle_count,
  output ctrl_state_t       state_dbg
`ifdef BRANCH_STATS_EN
  ,
  output logic [CYC_W-1:0]  br_count,
  output logic [CYC_W-1:0]  taken_count
`endif
);

  ctrl_state_t       state_q, state_d;
  logic              start_q, start_d;
  logic              halt_q, halt_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              zflag_q, zflag_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [PC_W-1:0]   start_addr_q, start_addr_d;

  logic go_accept;
  logic br_exec;
  logic cond_ok;

  always_comb begin
    go_accept = go && ((state_q == IDLE) || (state_q == HALTED));

    state_d = state_q;
    case (state_q)
      IDLE:    if (go_accept) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (halt_instr) state_d = HALTED;
      HALTED:  if (go_accept) state_d = LAUNCH;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    start_d   = (state_d == LAUNCH);
    running_d = (state_d == RUN);
    halt_d    = (state_d == IDLE) || (state_d == HALTED);
    done_d    = (state_q == RUN) && (state_d == HALTED);

    start_addr_d = go_accept ? go_addr : start_addr_q;

    branch  = br_valid && (state_q == RUN);
    br_exec = branch && !halt_instr;

    cond_ok = 1'b0;
    case (br_cond)
      COND_ALWAYS: cond_ok = 1'b1;
      COND_Z:      cond_ok = zflag_q;
      COND_NZ:     cond_ok = !zflag_q;
      COND_LOOP:   cond_ok = (loop_q > LOOP_W'(1));
      default:     cond_ok = 1'b0;
    endcase

    taken  = br_exec && cond_ok;
    target = pc_i + br_offset;

    zflag_d = flag_we ? alu_zero : zflag_q;

    // A load overrides the decrement of a loop branch in the same cycle.
    loop_d = loop_q;
    if (loop_ld)
      loop_d = loop_val;
    else if (br_exec && (br_cond == COND_LOOP) && (loop_q != '0))
      loop_d = loop_q - LOOP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      halt_q       <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      zflag_q      <= 1'b0;
      loop_q       <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      halt_q       <= halt_d;
      running_q    <= running_d;
      done_q       <= done_d;
      zflag_q      <= zflag_d;
      loop_q       <= loop_d;
      start_addr_q <= start_addr_d;
    end
  end

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (go_accept),
    .en    ((state_q == LAUNCH) || (state_q == RUN)),
    .count (cycle_count)
  );

`ifdef BRANCH_STATS_EN
  sat_counter #(.W(CYC_W)) u_br_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (go_accept),
    .en    (branch),
    .count (br_count)
  );

  sat_counter #(.W(CYC_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (go_accept),
    .en    (taken),
    .count (taken_count)
  );
`endif

  assign start      = start_q;
  assign halt       = halt_q;
  assign running    = running_q;
  assign done       = done_q;
  assign start_addr = start_addr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: launch, branches, loop counter, halt, relaunch
// and mid-run reset, each with hand-computed expectations.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        go;
  logic [7:0]  go_addr;
  logic [7:0]  pc_i;
  logic        br_valid;
  logic [1:0]  br_cond;
  logic [7:0]  br_offset;
  logic        alu_zero;
  logic        flag_we;
  logic        loop_ld;
  logic [7:0]  loop_val;
  logic        halt_instr;
  logic        start;
  logic [7:0]  start_addr;
  logic        branch;
  logic [7:0]  target;
  logic        taken;
  logic        halt;
  logic        running;
  logic        done;
  logic [31:0] cycle_count;
  ctrl_state_t state_dbg;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] taken_count;
`endif

  int n_checks;
  int n_pass;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .go_addr     (go_addr),
    .pc_i        (pc_i),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_offset   (br_offset),
    .alu_zero    (alu_zero),
    .flag_we     (flag_we),
    .loop_ld     (loop_ld),
    .loop_val    (loop_val),
    .halt_instr  (halt_instr),
    .start       (start),
    .start_addr  (start_addr),
    .branch      (branch),
    .target      (target),
    .taken       (taken),
    .halt        (halt),
    .running     (running),
    .done        (done),
    .cycle_count (cycle_count),
    .state_dbg   (state_dbg)
`ifdef BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic idle_inputs();
    go = 0; go_addr = 0; pc_i = 0; br_valid = 0; br_cond = 0; br_offset = 0;
    alu_zero = 0; flag_we = 0; loop_ld = 0; loop_val = 0; halt_instr = 0;
  endtask

  // Advance one clock; inputs are cleared just after the edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic set_br(input logic [1:0] cond, input logic [7:0] pc, input logic [7:0] off);
    br_valid = 1; br_cond = cond; pc_i = pc; br_offset = off;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_halt", 32'(halt), 1);
    chk("rst_start", 32'(start), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_start_addr", 32'(start_addr), 0);
    reset = 0;
    step();
    chk("idle_halt", 32'(halt), 1);
    go = 1; go_addr = 8'h10;
    step();
    // LAUNCH
    chk("launch_start", 32'(start), 1);
    chk("launch_addr", 32'(start_addr), 32'h10);
    chk("launch_halt", 32'(halt), 0);
    chk("launch_running", 32'(running), 0);
    chk("launch_cycles", cycle_count, 0);
    set_br(COND_ALWAYS, 8'h20, 8'hFC);
    chk("launch_no_taken", 32'(taken), 0);
    chk("launch_no_branch", 32'(branch), 0);
    step();
    // r1
    chk("run_start", 32'(start), 0);
    chk("run_running", 32'(running), 1);
    chk("run_halt", 32'(halt), 0);
    chk("run_cycles1", cycle_count, 1);
    set_br(COND_ALWAYS, 8'h20, 8'hFC);
    chk("br00_taken", 32'(taken), 1);
    chk("br00_target", 32'(target), 32'h1C);
    chk("br00_branch", 32'(branch), 1);
    pc_i = 8'hFE; br_offset = 8'h03; #1;
    chk("target_wrap", 32'(target), 32'h01);
    step();
    // r2: flag write and cond-01 in same cycle sees old flag
    flag_we = 1; alu_zero = 1;
    set_br(COND_Z, 8'h30, 8'h04);
    chk("z_old_flag", 32'(taken), 0);
    step();
    // r3
    set_br(COND_Z, 8'h30, 8'h04);
    chk("z_new_flag", 32'(taken), 1);
    br_cond = COND_NZ; #1;
    chk("nz_flag_set", 32'(taken), 0);
    loop_ld = 1; loop_val = 8'd3;
    step();
    // r4..r7: loop 3 -> taken 1,1,0 then 0 at count 0
    set_br(COND_LOOP, 8'h40, 8'hF0);
    chk("loop_3", 32'(taken), 1);
    step();
    set_br(COND_LOOP, 8'h40, 8'hF0);
    chk("loop_2", 32'(taken), 1);
    step();
    set_br(COND_LOOP, 8'h40, 8'hF0);
    chk("loop_1", 32'(taken), 0);
    step();
    set_br(COND_LOOP, 8'h40, 8'hF0);
    chk("loop_0", 32'(taken), 0);
    step();
    // r8: load and loop branch together, taken uses pre-load 0
    loop_ld = 1; loop_val = 8'd2;
    set_br(COND_LOOP, 8'h40, 8'hF0);
    chk("loop_ld_pre", 32'(taken), 0);
    step();
    // r9: halt with loop branch, counter stays 2
    halt_instr = 1;
    set_br(COND_LOOP, 8'h40, 8'hF0);
    chk("halt_br_taken", 32'(taken), 0);
    chk("run_cycles9", cycle_count, 9);
    step();
    // HALTED
    chk("h1_halt", 32'(halt), 1);
    chk("h1_done", 32'(done), 1);
    chk("h1_running", 32'(running), 0);
    chk("h1_cycles", cycle_count, 10);
    chk("h1_state", 32'(state_dbg), 32'(HALTED));
    set_br(COND_ALWAYS, 8'h20, 8'h01);
    chk("h1_no_taken", 32'(taken), 0);
    chk("h1_no_branch", 32'(branch), 0);
    step();
    chk("h2_done", 32'(done), 0);
    chk("h2_cycles", cycle_count, 10);
    // relaunch
    go = 1; go_addr = 8'h40;
    step();
    chk("re_launch_start", 32'(start), 1);
    chk("re_launch_addr", 32'(start_addr), 32'h40);
    chk("re_launch_cycles", cycle_count, 0);
    step();
    // r1: counter 2 preserved across halt
    set_br(COND_LOOP, 8'h50, 8'h02);
    chk("loop_kept", 32'(taken), 1);
    step();
    // r2: go ignored in RUN
    go = 1; go_addr = 8'h55;
    step();
    chk("go_ign_state", 32'(state_dbg), 32'(RUN));
    chk("go_ign_start", 32'(start), 0);
    chk("go_ign_addr", 32'(start_addr), 32'h40);
    step();
    step();
    // r5: halt + branch
    halt_instr = 1;
    set_br(COND_ALWAYS, 8'h50, 8'h02);
    chk("halt_wins", 32'(taken), 0);
    step();
    chk("p2_done", 32'(done), 1);
    chk("p2_halt", 32'(halt), 1);
    chk("p2_cycles", cycle_count, 6);
    step();
    chk("p2_done_pulse", 32'(done), 0);
    chk("p2_cycles_hold", cycle_count, 6);
    // third program, then reset mid-RUN
    go = 1; go_addr = 8'h80;
    step();
    step();
    loop_ld = 1; loop_val = 8'd5;
    flag_we = 1; alu_zero = 1;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("mr_state", 32'(state_dbg), 32'(IDLE));
    chk("mr_halt", 32'(halt), 1);
    chk("mr_running", 32'(running), 0);
    chk("mr_cycles", cycle_count, 0);
    chk("mr_start_addr", 32'(start_addr), 0);
    go = 1; go_addr = 8'h90;
    step();
    step();
    set_br(COND_Z, 8'h10, 8'h01);
    chk("mr_flag_clr", 32'(taken), 0);
    br_cond = COND_NZ; #1;
    chk("mr_nz", 32'(taken), 1);
    br_cond = COND_LOOP; #1;
    chk("mr_loop_clr", 32'(taken), 0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
